// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter sequencer.
package pc_pkg;

   // The sequencer is either fetching normally or parked after a misaligned redirect
   typedef enum logic {
      PC_RUN,
      PC_FAULT
   } pc_state_t;

   typedef enum logic [2:0] {
      SEL_SEQ,
      SEL_BRANCH,
      SEL_JUMP,
      SEL_TRAP,
      SEL_HOLD
   } next_pc_sel_t;

   // Only the two low address bits matter for the supported alignments of 2 and 4 bytes
   function automatic logic is_aligned(input logic [1:0] addr, input int unsigned ialign);
      if (ialign == 2)
         return (addr[0] == 1'b0);
      return (addr == 2'b00);
   endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack; the oldest entry is silently overwritten when a push arrives while full.
module return_address_stack #(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            update,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] pushData,
   output logic [XLEN-1:0] top,
   output logic            empty,
   output logic            full
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_COUNT = CNT_W'(RAS_DEPTH);

   logic [XLEN-1:0]  entries [RAS_DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] topIdx;
   logic [CNT_W-1:0] count;

   // ptr names the next free slot, so the newest entry always sits one slot behind it
   assign topIdx = ptr - PTR_W'(1);
   assign empty  = (count == '0);
   assign full   = (count == DEPTH_COUNT);
   assign top    = empty ? '0 : entries[topIdx];

   // A simultaneous push and pop swaps the top entry in place; on an empty stack it degrades to a plain push.
   // Pointer wrap on a full push reuses the oldest slot while the count saturates at the depth.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr   <= '0;
         count <= '0;
         for (int i = 0; i < RAS_DEPTH; i++)
            entries[i] <= '0;
      end else if (update) begin
         if (push && pop && !empty) begin
            entries[topIdx] <= pushData;
         end else if (push) begin
            entries[ptr] <= pushData;
            ptr          <= ptr + PTR_W'(1);
            if (!full)
               count <= count + CNT_W'(1);
         end else if (pop && !empty) begin
            ptr   <= topIdx;
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: redirect priority, misaligned-target fault hold and call/return prediction.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int               XLEN         = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
   parameter int unsigned      IALIGN       = 4,
   parameter int               RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            trap_enable,
   input  logic [XLEN-1:0] trap_vector,
   input  logic            jump_enable,
   input  logic [XLEN-1:0] jump_target_address,
   input  logic            branch_enable,
   input  logic [XLEN-1:0] branch_address,
   input  logic            ras_push,
   input  logic            ras_pop,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic [XLEN-1:0] ras_top,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            misaligned_fault,
   output logic [XLEN-1:0] fault_address
);

   pc_state_t       state;
   next_pc_sel_t    nextSel;
   logic [XLEN-1:0] redirectTarget;
   logic [XLEN-1:0] nextPc;
   logic            targetMisaligned;
   logic            rasUpdate;

   assign pc_plus4 = pc + XLEN'(4);

   // Pick the next-PC source; while faulted only a trap can move the PC, everything else holds it
   always_comb begin
      nextSel = SEL_SEQ;
      if (state == PC_FAULT)
         nextSel = trap_enable ? SEL_TRAP : SEL_HOLD;
      else if (trap_enable)
         nextSel = SEL_TRAP;
      else if (stall)
         nextSel = SEL_HOLD;
      else if (jump_enable)
         nextSel = SEL_JUMP;
      else if (branch_enable)
         nextSel = SEL_BRANCH;
   end

   // Only the winning redirect is alignment-checked, and trap vectors are trusted as-is
   assign redirectTarget   = (nextSel == SEL_JUMP) ? jump_target_address : branch_address;
   assign targetMisaligned = ((nextSel == SEL_JUMP) || (nextSel == SEL_BRANCH)) &&
                             !is_aligned(redirectTarget[1:0], IALIGN);
   assign rasUpdate        = (state == PC_RUN) && !trap_enable && !stall && !targetMisaligned;

   // A misaligned redirect is refused, so the PC stays put instead of taking the target
   always_comb begin
      nextPc = pc_plus4;
      case (nextSel)
         SEL_TRAP:             nextPc = trap_vector;
         SEL_JUMP, SEL_BRANCH: nextPc = targetMisaligned ? pc : redirectTarget;
         SEL_HOLD:             nextPc = pc;
         default:              nextPc = pc_plus4;
      endcase
   end

   // PC register and RUN/FAULT state machine; fault_address survives the trap exit until the next fault
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc               <= RESET_VECTOR;
         state            <= PC_RUN;
         misaligned_fault <= 1'b0;
         fault_address    <= '0;
      end else begin
         pc <= nextPc;
         case (state)
            PC_RUN: begin
               if (targetMisaligned) begin
                  state            <= PC_FAULT;
                  misaligned_fault <= 1'b1;
                  fault_address    <= redirectTarget;
               end
            end
            PC_FAULT: begin
               if (trap_enable) begin
                  state            <= PC_RUN;
                  misaligned_fault <= 1'b0;
               end
            end
            default: state <= PC_RUN;
         endcase
      end
   end

   return_address_stack #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) rasInst (
      .clk      (clk),
      .reset    (reset),
      .update   (rasUpdate),
      .push     (ras_push),
      .pop      (ras_pop),
      .pushData (pc_plus4),
      .top      (ras_top),
      .empty    (ras_empty),
      .full     (ras_full)
   );

endmodule
